// File: rtl/lab2_proc_alu_pkg.sv
// Shared function codes, FSM states and helpers for the lab2 iterative ALU.
package lab2_proc_alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_MUL  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SLL  = 5'd10;
  localparam logic [4:0] ALU_CP_A = 5'd11;
  localparam logic [4:0] ALU_CP_B = 5'd12;
  localparam logic [4:0] ALU_JALR = 5'd13;
  localparam logic [4:0] ALU_DIV  = 5'd14;
  localparam logic [4:0] ALU_DIVU = 5'd15;
  localparam logic [4:0] ALU_REM  = 5'd16;
  localparam logic [4:0] ALU_REMU = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // True for functions that run through the shift-add / restoring-divide unit.
  function automatic logic is_iterative(input logic [4:0] fn);
    return (fn == ALU_MUL)  || (fn == ALU_DIV) || (fn == ALU_DIVU) ||
           (fn == ALU_REM)  || (fn == ALU_REMU);
  endfunction

endpackage

// File: rtl/lab2_proc_iter_muldiv_unit.sv
// Iterative shift-add multiplier and restoring divider with sign fix-up.
module lab2_proc_iter_muldiv_unit
  import lab2_proc_alu_pkg::*;
#(
  parameter int unsigned p_nbits     = 32,
  parameter bit          p_early_out = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               calc,
  input  logic [4:0]         fn,
  input  logic [p_nbits-1:0] op_a,
  input  logic [p_nbits-1:0] op_b,
  output logic               done_c,
  output logic [p_nbits-1:0] result_c
);

  localparam int unsigned CW = $clog2(p_nbits) + 1;
  localparam logic [p_nbits-1:0] MIN_NEG = {1'b1, {(p_nbits-1){1'b0}}};

  // x: multiplicand / dividend shifting into quotient; y: multiplier / divisor;
  // acc: product / partial remainder.
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [p_nbits-1:0] x_q, x_d;
  logic [p_nbits-1:0] y_q, y_d;
  logic [p_nbits-1:0] acc_q, acc_d;
  logic               is_mul_q, is_mul_d;
  logic               is_rem_q, is_rem_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic               ovf_q, ovf_d;

  logic               is_signed;
  logic               a_neg, b_neg;
  logic [p_nbits:0]   trial;
  logic [p_nbits:0]   diff;
  logic [p_nbits-1:0] quo_mag, rem_mag;

  // Operand capture on start, one multiply or divide step per calc cycle.
  always_comb begin
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    is_mul_d   = is_mul_q;
    is_rem_d   = is_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    is_signed  = (fn == ALU_DIV) || (fn == ALU_REM);
    a_neg      = is_signed && op_a[p_nbits-1];
    b_neg      = is_signed && op_b[p_nbits-1];
    trial      = {acc_q, x_q[p_nbits-1]};
    diff       = trial - {1'b0, y_q};

    if (start) begin
      cnt_d      = CW'(p_nbits);
      is_mul_d   = (fn == ALU_MUL);
      is_rem_d   = (fn == ALU_REM) || (fn == ALU_REMU);
      neg_quo_d  = a_neg ^ b_neg;
      neg_rem_d  = a_neg;
      div_zero_d = (op_b == '0);
      ovf_d      = is_signed && (op_a == MIN_NEG) && (op_b == '1);
      acc_d      = '0;
      if (fn == ALU_MUL) begin
        x_d = op_a;
        y_d = op_b;
      end else begin
        x_d = a_neg ? -op_a : op_a;
        y_d = b_neg ? -op_b : op_b;
      end
    end else if (calc) begin
      cnt_d = cnt_q - CW'(1);
      if (is_mul_q) begin
        acc_d = acc_q + (y_q[0] ? x_q : '0);
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
      end else if (trial >= {1'b0, y_q}) begin
        acc_d = diff[p_nbits-1:0];
        x_d   = {x_q[p_nbits-2:0], 1'b1};
      end else begin
        acc_d = trial[p_nbits-1:0];
        x_d   = {x_q[p_nbits-2:0], 1'b0};
      end
    end
  end

  // Completion and final result, taken from the values of the last step.
  always_comb begin
    done_c   = calc && ((cnt_q == CW'(1)) ||
                        (p_early_out && is_mul_q && (y_d == '0)));
    quo_mag  = x_d;
    rem_mag  = acc_d;
    result_c = '0;
    if (is_mul_q) begin
      result_c = acc_d;
    end else if (is_rem_q) begin
      if (ovf_q)          result_c = '0;
      else if (neg_rem_q) result_c = -rem_mag;
      else                result_c = rem_mag;
    end else begin
      if (div_zero_q)     result_c = '1;
      else if (ovf_q)     result_c = MIN_NEG;
      else if (neg_quo_q) result_c = -quo_mag;
      else                result_c = quo_mag;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      is_mul_q   <= 1'b0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      is_mul_q   <= is_mul_d;
      is_rem_q   <= is_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: rtl/lab2_proc_iter_alu.sv
// Multi-cycle X-stage ALU: single-cycle ops plus iterative MUL/DIV/REM, val/rdy.
module lab2_proc_iter_alu
  import lab2_proc_alu_pkg::*;
#(
  parameter int unsigned p_nbits     = 32,
  parameter bit          p_early_out = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [4:0]         req_fn,
  input  logic [p_nbits-1:0] req_op_a,
  input  logic [p_nbits-1:0] req_op_b,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_result,
  output logic               resp_eq,
  output logic               resp_lt,
  output logic               resp_ltu,
  output logic               busy
);

  localparam int unsigned SHW = $clog2(p_nbits);

  state_e             state_q, state_d;
  logic               req_rdy_q, req_rdy_d;
  logic               resp_val_q, resp_val_d;
  logic               busy_q, busy_d;
  logic [p_nbits-1:0] result_q, result_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;
  logic               ltu_q, ltu_d;

  logic               accept;
  logic               md_start;
  logic               md_done_c;
  logic [p_nbits-1:0] md_result_c;
  logic [p_nbits-1:0] alu_c;
  logic [p_nbits-1:0] sum_c;
  logic [SHW-1:0]     shamt;
  logic               eq_c, lt_c, ltu_c;

  assign accept   = req_val && (state_q == IDLE);
  assign md_start = accept && is_iterative(req_fn);

  lab2_proc_iter_muldiv_unit #(
    .p_nbits     (p_nbits),
    .p_early_out (p_early_out)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start),
    .calc     (state_q == CALC),
    .fn       (req_fn),
    .op_a     (req_op_a),
    .op_b     (req_op_b),
    .done_c   (md_done_c),
    .result_c (md_result_c)
  );

  // Comparators and single-cycle function mux on the incoming operands.
  always_comb begin
    eq_c  = (req_op_a == req_op_b);
    lt_c  = ($signed(req_op_a) < $signed(req_op_b));
    ltu_c = (req_op_a < req_op_b);
    sum_c = req_op_a + req_op_b;
    shamt = req_op_b[SHW-1:0];
    alu_c = '0;
    case (req_fn)
      ALU_ADD:  alu_c = sum_c;
      ALU_SUB:  alu_c = req_op_a - req_op_b;
      ALU_AND:  alu_c = req_op_a & req_op_b;
      ALU_OR:   alu_c = req_op_a | req_op_b;
      ALU_XOR:  alu_c = req_op_a ^ req_op_b;
      ALU_SLT:  alu_c = {{(p_nbits-1){1'b0}}, lt_c};
      ALU_SLTU: alu_c = {{(p_nbits-1){1'b0}}, ltu_c};
      ALU_SRA:  alu_c = $signed(req_op_a) >>> shamt;
      ALU_SRL:  alu_c = req_op_a >> shamt;
      ALU_SLL:  alu_c = req_op_a << shamt;
      ALU_CP_A: alu_c = req_op_a;
      ALU_CP_B: alu_c = req_op_b;
      ALU_JALR: alu_c = {sum_c[p_nbits-1:1], 1'b0};
      default:  alu_c = '0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          eq_d  = eq_c;
          lt_d  = lt_c;
          ltu_d = ltu_c;
          if (is_iterative(req_fn)) begin
            state_d = CALC;
          end else begin
            state_d  = DONE;
            result_d = alu_c;
          end
        end
      end
      CALC: begin
        if (md_done_c) begin
          state_d  = DONE;
          result_d = md_result_c;
        end
      end
      DONE: begin
        if (resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_rdy_d  = (state_d == IDLE);
    resp_val_d = (state_d == DONE);
    busy_d     = (state_d == CALC);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
      busy_q     <= 1'b0;
      result_q   <= '0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      ltu_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_rdy_q  <= req_rdy_d;
      resp_val_q <= resp_val_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
      eq_q       <= eq_d;
      lt_q       <= lt_d;
      ltu_q      <= ltu_d;
    end
  end

  assign req_rdy     = req_rdy_q;
  assign resp_val    = resp_val_q;
  assign busy        = busy_q;
  assign resp_result = result_q;
  assign resp_eq     = eq_q;
  assign resp_lt     = lt_q;
  assign resp_ltu    = ltu_q;

endmodule

// File: tb/tb_lab2_proc_iter_alu.sv
// Randomised and directed checks of lab2_proc_iter_alu against an arithmetic model.
module tb_lab2_proc_iter_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic [4:0]  req_fn;
  logic [31:0] req_op_a, req_op_b;
  logic        resp_rdy;

  logic        req_rdy, resp_val, resp_eq, resp_lt, resp_ltu, busy;
  logic [31:0] resp_result;
  logic        eo_req_rdy, eo_resp_val, eo_resp_eq, eo_resp_lt, eo_resp_ltu, eo_busy;
  logic [31:0] eo_resp_result;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  lab2_proc_iter_alu #(.p_nbits(32), .p_early_out(1'b0)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
    .req_fn(req_fn), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_result(resp_result),
    .resp_eq(resp_eq), .resp_lt(resp_lt), .resp_ltu(resp_ltu), .busy(busy)
  );

  lab2_proc_iter_alu #(.p_nbits(32), .p_early_out(1'b1)) dut_eo (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(eo_req_rdy),
    .req_fn(req_fn), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .resp_val(eo_resp_val), .resp_rdy(resp_rdy), .resp_result(eo_resp_result),
    .resp_eq(eo_resp_eq), .resp_lt(eo_resp_lt), .resp_ltu(eo_resp_ltu), .busy(eo_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_iter(input logic [4:0] fn);
    return fn == 5'd2 || (fn >= 5'd14 && fn <= 5'd17);
  endfunction

  // Behavioural result from the function definitions with plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    bit ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    case (fn)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
      5'd3:  return a & b;
      5'd4:  return a | b;
      5'd5:  return a ^ b;
      5'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd7:  return (a < b) ? 32'd1 : 32'd0;
      5'd8:  return $signed(a) >>> (b % 32);
      5'd9:  return a >> (b % 32);
      5'd10: return a << (b % 32);
      5'd11: return a;
      5'd12: return b;
      5'd13: return (a + b) & 32'hffff_fffe;
      5'd14: return (b == 0) ? 32'hffff_ffff : ovf ? a : 32'($signed(a) / $signed(b));
      5'd15: return (b == 0) ? 32'hffff_ffff : a / b;
      5'd16: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Early-out MUL runs one CALC cycle per significant multiplier bit (minimum one).
  function automatic int ref_eo_lat(input logic [31:0] b);
    int bits;
    bits = 1;
    for (int i = 0; i < 32; i++) if (b[i]) bits = i + 1;
    return bits + 1;
  endfunction

  task automatic do_op(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit keep_req);
    logic [31:0] er;
    int lat, eo_lat, exp_lat;
    bit got;
    er      = ref_alu(fn, a, b);
    exp_lat = ref_iter(fn) ? 33 : 1;
    @(negedge clk);
    chk("req_rdy_idle", 32'(req_rdy), 32'd1);
    req_val  = 1'b1;
    req_fn   = fn;
    req_op_a = a;
    req_op_b = b;
    @(posedge clk);
    #1;
    if (!keep_req) req_val = 1'b0;
    lat = 0; eo_lat = 0; got = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (eo_resp_val && eo_lat == 0) eo_lat = c;
      if (c == 1 && exp_lat > 1) chk("busy_calc", 32'(busy), 32'd1);
      if (c == 2 && keep_req && exp_lat > 2) chk("req_rdy_calc", 32'(req_rdy), 32'd0);
      if (resp_val) begin lat = c; got = 1; end
    end
    req_val = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", resp_result, er);
    chk("eq", 32'(resp_eq), 32'(a == b));
    chk("lt", 32'(resp_lt), 32'($signed(a) < $signed(b)));
    chk("ltu", 32'(resp_ltu), 32'(a < b));
    if (fn == 5'd2) begin
      chk("eo_result", eo_resp_result, er);
      chk("eo_latency", 32'(eo_lat), 32'(ref_eo_lat(b)));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_val", 32'(resp_val), 32'd1);
      chk("hold_result", resp_result, er);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    chk("post_val", 32'(resp_val), 32'd0);
    chk("post_rdy", 32'(req_rdy), 32'd1);
  endtask

  initial begin
    logic [4:0]  fn;
    logic [31:0] a, b;
    reset = 1'b1; req_val = 1'b0; req_fn = '0; req_op_a = '0; req_op_b = '0; resp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_flags", {29'd0, resp_eq, resp_lt, resp_ltu}, 32'd0);
    reset = 1'b0;

    do_op(5'd0,  32'h7fff_ffff, 32'd1, 3, 1'b0);
    do_op(5'd2,  32'hffff_fffe, 32'd3, 0, 1'b0);
    do_op(5'd14, 32'hffff_fff9, 32'd2, 1, 1'b0);
    do_op(5'd16, 32'hffff_fff9, 32'd2, 0, 1'b0);
    do_op(5'd15, 32'h8000_0000, 32'h10, 0, 1'b0);
    do_op(5'd14, 32'h8000_0000, 32'hffff_ffff, 0, 1'b0);
    do_op(5'd16, 32'h8000_0000, 32'hffff_ffff, 0, 1'b0);
    do_op(5'd15, 32'd5, 32'd0, 0, 1'b0);
    do_op(5'd17, 32'd5, 32'd0, 0, 1'b0);
    do_op(5'd14, 32'hffff_fffb, 32'd0, 0, 1'b0);
    do_op(5'd16, 32'hffff_fffb, 32'd0, 0, 1'b0);
    do_op(5'd8,  32'h8000_0000, 32'h21, 0, 1'b1);
    do_op(5'd14, 32'd100, 32'd7, 2, 1'b1);
    do_op(5'd13, 32'd7, 32'd4, 0, 1'b0);
    do_op(5'd25, 32'd7, 32'd4, 0, 1'b0);

    // Reset in the middle of a divide discards it.
    @(negedge clk);
    req_val = 1'b1; req_fn = 5'd14; req_op_a = 32'd1000; req_op_b = 32'd3;
    @(negedge clk);
    req_val = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_req_rdy", 32'(req_rdy), 32'd1);
    chk("midrst_resp_val", 32'(resp_val), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(5'd0, 32'd2, 32'd2, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      fn = 5'($urandom_range(0, 19));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 40));
        2: a = 32'h8000_0000;
        3: b = 32'hffff_ffff;
        4: a = b;
        default: ;
      endcase
      do_op(fn, a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
